uart_tx_arbiter: RTL and testbench

//  Shares one wb_uart_tx byte port between N requesters with message-level locking.

---
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter that funnels N byte streams into one wb_uart_tx port.
// A single holding register feeds the strobe, and a credit check keeps the downstream queue from overflowing.
module uart_tx_arbiter #(
  parameter int N       = 2,
  parameter int BUFFER  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              req_vld,
  input  logic [8*N-1:0]            req_dat,
  input  logic [N-1:0]              req_last,
  output logic [N-1:0]              req_rdy,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [7:0]                dat_o,
  input  logic                      ack_i,
  input  logic [$clog2(BUFFER):0]   size_i,
  output logic                      busy,
  output logic [$clog2(N)-1:0]      owner
);

  localparam int OW = $clog2(N);
  localparam int CW = $clog2(BUFFER) + 2;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, LOCK, DRAIN} state_t;

  state_t          state;
  logic [OW-1:0]   rr_ptr;
  logic            hold_vld;
  logic [7:0]      hold_dat;
  logic            push_q;
  logic [TW-1:0]   idle_cnt;

  logic            credit_ok;
  logic            accept;
  logic            own_vld;
  logic            own_last;
  logic [7:0]      own_dat;
  logic            take;
  logic            timeout_hit;
  logic [OW-1:0]   grant;

  // First requester with req_vld, scanning upward from the round-robin pointer.
  function automatic logic [OW-1:0] rr_pick(input logic [N-1:0] v, input logic [OW-1:0] p);
    logic [OW-1:0] g;
    logic          found;
    int            j;
    g     = p;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(p) + k;
      if (j >= N) j -= N;
      if (!found && v[j]) begin
        g     = OW'(j);
        found = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [OW-1:0] rr_next(input logic [OW-1:0] p);
    return (p == OW'(N - 1)) ? '0 : p + 1'b1;
  endfunction

  // size_i lags a write by one cycle, so the byte pushed last cycle is counted explicitly.
  assign credit_ok = (CW'(size_i) + CW'(push_q)) < CW'(BUFFER);
  assign stb_o     = hold_vld & credit_ok;
  assign we_o      = stb_o;
  assign dat_o     = hold_dat;
  assign accept    = stb_o & ack_i;
  assign busy      = (state != IDLE) | hold_vld;

  assign own_vld     = req_vld[owner];
  assign own_last    = req_last[owner];
  assign own_dat     = req_dat[int'(owner)*8 +: 8];
  assign take        = (state == LOCK) & own_vld & (~hold_vld | accept);
  assign timeout_hit = (TIMEOUT != 0) && (state == LOCK) && !own_vld && (idle_cnt == TO_LAST);
  assign grant       = rr_pick(req_vld, rr_ptr);

  // NOTE: every output of this always_comb gets a default before any branch, so no latch is inferred.
  always_comb begin
    req_rdy = '0;
    if (state == LOCK) req_rdy[owner] = ~hold_vld | accept;
  end

  // NOTE: state is updated with non-blocking assignments only, so every branch reads pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      hold_vld <= 1'b0;
      hold_dat <= '0;
      push_q   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      push_q <= accept;

      // A refill in the same cycle as an accept keeps the register full with the new byte.
      if (take) begin
        hold_vld <= 1'b1;
        hold_dat <= own_dat;
      end else if (accept) begin
        hold_vld <= 1'b0;
      end

      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (|req_vld) begin
            owner  <= grant;
            rr_ptr <= rr_next(grant);
            state  <= LOCK;
          end
        end
        LOCK: begin
          if (own_vld)                  idle_cnt <= '0;
          else if (idle_cnt != TO_LAST) idle_cnt <= idle_cnt + 1'b1;
          if ((take && own_last) || timeout_hit) state <= DRAIN;
        end
        DRAIN: begin
          if (!hold_vld || accept) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: senders push expected bytes as they are taken,
// a monitor pops and compares on every downstream accept against a small wb_uart_tx queue model.
module tb_uart_tx_arbiter;

  localparam int N   = 2;
  localparam int BUF = 4;
  localparam int TO  = 8;
  localparam int SW  = $clog2(BUF) + 1;

  typedef struct packed {
    logic       own;
    logic [7:0] dat;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_vld = '0;
  logic [8*N-1:0] req_dat = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_rdy;
  logic           stb_o;
  logic           we_o;
  logic [7:0]     dat_o;
  logic           ack_i;
  logic [SW-1:0]  size_i;
  logic           busy;
  logic           owner;

  logic           ack_q;
  logic           pend;
  logic [SW-1:0]  cnt;
  logic           ack_en   = 1'b1;
  logic           drain_en = 1'b1;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   acc_cnt  = 0;
  int   take_cyc [N];
  exp_t exp_q[$];
  int   take_log[$];
  int   acc_cyc[$];

  uart_tx_arbiter #(.N(N), .BUFFER(BUF), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_dat  (req_dat),
    .req_last (req_last),
    .req_rdy  (req_rdy),
    .stb_o    (stb_o),
    .we_o     (we_o),
    .dat_o    (dat_o),
    .ack_i    (ack_i),
    .size_i   (size_i),
    .busy     (busy),
    .owner    (owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Downstream model: registered ack, queue write one cycle after the accept, optional drain.
  assign ack_i  = ack_q;
  assign size_i = cnt;
  always @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      pend  <= 1'b0;
      cnt   <= '0;
    end else begin
      ack_q <= stb_o & ack_en;
      pend  <= stb_o & ack_i;
      cnt   <= cnt + SW'(pend) - SW'(drain_en && cnt != 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && stb_o && ack_i) begin
      exp_t e;
      acc_cnt++;
      acc_cyc.push_back(cyc);
      check("room_in_queue", 32'(int'(cnt) + int'(pend) < BUF), 32'd1);
      check("we_eq_stb", 32'(we_o), 32'd1);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got byte 0x%0h with nothing expected", dat_o);
      end else begin
        e = exp_q.pop_front();
        check("sb_dat", 32'(dat_o), 32'(e.dat));
        check("sb_owner", 32'(owner), 32'(e.own));
      end
    end
  end

  task automatic send(input int idx, input logic [7:0] b, input logic l);
    int   n;
    exp_t e;
    n = 0;
    req_vld[idx]          = 1'b1;
    req_dat[8*idx +: 8]   = b;
    req_last[idx]         = l;
    forever begin
      @(negedge clk);
      if (req_rdy[idx]) break;
      n++;
      if (n > 200) break;
    end
    if (n > 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: requester %0d byte 0x%0h never taken", idx, b);
    end else begin
      e.own = idx[0];
      e.dat = b;
      exp_q.push_back(e);
      take_log.push_back(idx);
      take_cyc[idx] = cyc;
    end
    @(posedge clk);
    #1 req_vld[idx] = 1'b0;
  endtask

  task automatic wait_acc(input int target, input string name);
    int n;
    n = 0;
    while (acc_cnt < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(acc_cnt), 32'(target));
  endtask

  task automatic do_reset();
    req_vld  = '0;
    req_last = '0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int lbase;
    int c1;
    int n;

    do_reset();
    @(negedge clk);
    check("rst_stb", 32'(stb_o), 32'd0);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_dat", 32'(dat_o), 32'd0);
    check("rst_rdy", 32'(req_rdy), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);

    // Single requester, three-byte message.
    base = acc_cnt;
    send(0, 8'h41, 1'b0);
    send(0, 8'h42, 1'b0);
    send(0, 8'h0A, 1'b1);
    wait_acc(base + 3, "t1_accepts");
    @(negedge clk);
    check("t1_idle_after_last", 32'(busy), 32'd0);

    // Two requesters valid from reset: whole message 0, then message 1, then pointer back at 0.
    do_reset();
    base  = acc_cnt;
    lbase = take_log.size();
    fork
      begin send(0, 8'hA0, 1'b0); send(0, 8'hA1, 1'b0); send(0, 8'hA2, 1'b1); end
      begin send(1, 8'hB0, 1'b0); send(1, 8'hB1, 1'b0); send(1, 8'hB2, 1'b1); end
    join
    fork
      send(0, 8'hC0, 1'b1);
      send(1, 8'hD0, 1'b1);
    join
    wait_acc(base + 8, "t2_accepts");
    begin
      int exp_log [8] = '{0, 0, 0, 1, 1, 1, 0, 1};
      for (int i = 0; i < 8; i++) begin
        if (lbase + i < take_log.size())
          check($sformatf("t2_grant_order_%0d", i), 32'(take_log[lbase + i]), 32'(exp_log[i]));
        else
          check($sformatf("t2_grant_order_%0d", i), 32'hFFFF_FFFF, 32'(exp_log[i]));
      end
    end

    // Credit limit: BUFFER=4 with no draining lets exactly four bytes through.
    do_reset();
    drain_en = 1'b0;
    base     = acc_cnt;
    fork
      begin
        send(0, 8'h10, 1'b0); send(0, 8'h11, 1'b0); send(0, 8'h12, 1'b0);
        send(0, 8'h13, 1'b0); send(0, 8'h14, 1'b0); send(0, 8'h15, 1'b1);
      end
    join_none
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("t3_four_accepts", 32'(acc_cnt - base), 32'd4);
    check("t3_stb_stalled", 32'(stb_o), 32'd0);
    check("t3_queue_full", 32'(cnt), 32'd4);
    @(posedge clk);
    #1 drain_en = 1'b1;
    @(posedge clk);
    #1 drain_en = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t3_fifth_after_drain", 32'(acc_cnt - base), 32'd5);
    drain_en = 1'b1;
    wait_acc(base + 6, "t3_all_accepts");

    // Idle timeout: owner 0 stalls after one byte, requester 1 is waiting.
    do_reset();
    base = acc_cnt;
    fork
      send(1, 8'h66, 1'b1);
    join_none
    send(0, 8'h55, 1'b0);
    n  = 0;
    c1 = -1;
    while (n < 100) begin
      @(negedge clk);
      if (req_rdy[1]) begin
        c1 = cyc;
        break;
      end
      n++;
    end
    check("t4_release_gap", 32'(c1 - take_cyc[0]), 32'd11);
    wait_acc(base + 2, "t4_accepts");

    // Reset while the holding register is full.
    do_reset();
    ack_en = 1'b0;
    base   = acc_cnt;
    send(0, 8'h77, 1'b0);
    @(negedge clk);
    check("t5_stb_before_rst", 32'(stb_o), 32'd1);
    check("t5_busy_before_rst", 32'(busy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_stb_after_rst", 32'(stb_o), 32'd0);
    check("t5_rdy_after_rst", 32'(req_rdy), 32'd0);
    check("t5_busy_after_rst", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    ack_en = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t5_byte_dropped", 32'(acc_cnt - base), 32'd0);

    // Back-to-back streaming: one accept per cycle after the first.
    do_reset();
    base  = acc_cnt;
    lbase = acc_cyc.size();
    send(0, 8'h80, 1'b0);
    c1 = take_cyc[0];
    for (int i = 1; i < 8; i++) send(0, 8'h80 + 8'(i), i == 7);
    wait_acc(base + 8, "t6_accepts");
    if (acc_cyc.size() >= lbase + 8) begin
      check("t6_first_latency", 32'(acc_cyc[lbase] - c1), 32'd2);
      check("t6_stream_span", 32'(acc_cyc[lbase + 7] - acc_cyc[lbase]), 32'd7);
    end else begin
      check("t6_accept_log", 32'(acc_cyc.size() - lbase), 32'd8);
    end

    repeat (4) @(posedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
